// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit multicycle processor: data width,
// data-memory responder state encodings and the memory opcode values.
package proc_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        MR_IDLE = 2'b00,
        MR_WAIT = 2'b01,
        MR_RESP = 2'b10
    } mr_state_t;

    localparam logic [3:0] OP_LW = 4'b0001;
    localparam logic [3:0] OP_SW = 4'b0010;

endpackage

// File: rtl/mem_responder_mem_array.sv
// DEPTH x DATA_W synchronous single-port RAM. A write stores wdata; a read
// loads the registered output. The output holds whenever no read is issued.
module mem_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Single port: either write the addressed word or register its contents.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: captures a single-cycle MemRead/MemWrite request,
// waits WAIT_CYCLES, performs the access and returns a one-cycle mem_ready.
// Protocol violations (both strobes, or any strobe while busy) and
// out-of-range addresses pulse mem_err.
module mem_responder #(
    parameter int DATA_W      = proc_pkg::DATA_W,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              mem_err
);

    import proc_pkg::*;

    mr_state_t         state;
    logic [3:0]        cnt;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              range_err_q;
    logic              rd_zero_q;

    logic              strobe_any;
    logic              strobe_one;
    logic              addr_oor;
    logic              capture;
    logic              ram_en;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;

    assign strobe_any = MemRead | MemWrite;
    assign strobe_one = MemRead ^ MemWrite;
    assign addr_oor   = (addr >> ADDR_W) != 16'd0;
    assign capture    = rst && (state == MR_IDLE) && strobe_one;

    // The access happens on the RESP edge; an asserted reset or an
    // out-of-range address keeps the array untouched.
    assign ram_en = rst && (state == MR_RESP) && !range_err_q;
    assign ram_we = (op_q == OP_SW);

    // rdata shows the last completed read: zero after reset or after an
    // out-of-range read, otherwise the RAM output register.
    assign rdata = rd_zero_q ? '0 : ram_q;

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_q)
    );

    // Request capture: opcode, address, store data and range status.
    always_ff @(posedge clk) begin
        if (capture) begin
            op_q        <= MemWrite ? OP_SW : OP_LW;
            addr_q      <= addr[ADDR_W-1:0];
            wdata_q     <= wdata;
            range_err_q <= addr_oor;
        end
    end

    // Control FSM: IDLE -> WAIT -> RESP -> IDLE with registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= MR_IDLE;
            cnt       <= 4'd0;
            mem_ready <= 1'b0;
            mem_busy  <= 1'b0;
            mem_err   <= 1'b0;
            rd_zero_q <= 1'b1;
        end else begin
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            case (state)
                MR_IDLE: begin
                    if (MemRead && MemWrite) begin
                        mem_err <= 1'b1;
                    end else if (strobe_one) begin
                        cnt      <= 4'(WAIT_CYCLES);
                        mem_busy <= 1'b1;
                        state    <= (WAIT_CYCLES == 0) ? MR_RESP : MR_WAIT;
                    end
                end
                MR_WAIT: begin
                    if (strobe_any) begin
                        mem_err <= 1'b1;
                    end
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= MR_RESP;
                    end
                end
                MR_RESP: begin
                    mem_ready <= 1'b1;
                    mem_busy  <= 1'b0;
                    mem_err   <= range_err_q | strobe_any;
                    if (op_q == OP_LW) begin
                        rd_zero_q <= range_err_q;
                    end
                    state <= MR_IDLE;
                end
                default: begin
                    mem_busy <= 1'b0;
                    state    <= MR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a table of read/write transactions on a
// WAIT_CYCLES=2 instance, hand-written protocol/reset corner cases, and
// back-to-back traffic on a WAIT_CYCLES=0 instance.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        rd_a = 1'b0, wr_a = 1'b0;
    logic [15:0] addr_a = '0, wdata_a = '0;
    logic [15:0] rdata_a;
    logic        ready_a, busy_a, err_a;

    logic        rd_b = 1'b0, wr_b = 1'b0;
    logic [15:0] addr_b = '0, wdata_b = '0;
    logic [15:0] rdata_b;
    logic        ready_b, busy_b, err_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .rst(rst), .MemRead(rd_a), .MemWrite(wr_a),
        .addr(addr_a), .wdata(wdata_a), .rdata(rdata_a),
        .mem_ready(ready_a), .mem_busy(busy_a), .mem_err(err_a)
    );

    mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst), .MemRead(rd_b), .MemWrite(wr_b),
        .addr(addr_b), .wdata(wdata_b), .rdata(rdata_b),
        .mem_ready(ready_b), .mem_busy(busy_b), .mem_err(err_b)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int inst, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [15:0] wd);
        if (inst == 0) begin
            rd_a = rd; wr_a = wr; addr_a = a; wdata_a = wd;
        end else begin
            rd_b = rd; wr_b = wr; addr_b = a; wdata_b = wd;
        end
    endtask

    task automatic sample(input int inst, output logic [15:0] rd, output logic rdy,
                          output logic bsy, output logic er);
        if (inst == 0) begin
            rd = rdata_a; rdy = ready_a; bsy = busy_a; er = err_a;
        end else begin
            rd = rdata_b; rdy = ready_b; bsy = busy_b; er = err_b;
        end
    endtask

    // Called #1 after a clock edge; the strobe is captured at the next edge.
    task automatic txn(input int inst, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] exp_rd, input logic exp_err, input string tag);
        logic [15:0] o_rd;
        logic        o_rdy, o_bsy, o_err;
        int          n;
        int          exp_lat;
        exp_lat = (inst == 0) ? 3 : 1;
        drive(inst, rd, wr, a, wd);
        @(posedge clk); #1;
        drive(inst, 1'b0, 1'b0, 16'h0, 16'h0);
        sample(inst, o_rd, o_rdy, o_bsy, o_err);
        check({tag, " busy_after_capture"}, {31'd0, o_bsy}, 32'd1);
        check({tag, " no_ready_at_capture"}, {31'd0, o_rdy}, 32'd0);
        n = 1;
        forever begin
            if (n > 20) break;
            @(posedge clk); #1;
            sample(inst, o_rd, o_rdy, o_bsy, o_err);
            if (o_rdy) break;
            n++;
        end
        if (n > 20) begin
            tests++; fails++;
            $display("FAIL %s timeout: no mem_ready within 20 cycles", tag);
        end else begin
            check({tag, " latency"}, n, exp_lat);
            check({tag, " rdata"}, {16'd0, o_rd}, {16'd0, exp_rd});
            check({tag, " err"}, {31'd0, o_err}, {31'd0, exp_err});
            check({tag, " busy_at_ready"}, {31'd0, o_bsy}, 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 16'h0012, 16'hBEEF, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 16'h0112, 16'h1234, 16'hBEEF, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 16'h0112, 16'h0000, 16'h0000, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 16'hBEEF, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 16'h00FF, 16'h5A5A, 16'hBEEF, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h5A5A, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 16'h0000, 16'h0001, 16'h5A5A, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0001, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 16'h8012, 16'h0000, 16'h0000, 1'b1};

        // Reset then idle
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset rdata", {16'd0, rdata_a}, 32'd0);
        check("reset ready", {31'd0, ready_a}, 32'd0);
        check("reset busy", {31'd0, busy_a}, 32'd0);
        check("reset err", {31'd0, err_a}, 32'd0);

        // Table-driven transactions
        for (int i = 0; i < 10; i++) begin
            txn(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Both strobes in IDLE: error next cycle, no access started
        drive(0, 1'b1, 1'b1, 16'h0012, 16'h7777);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        check("both err", {31'd0, err_a}, 32'd1);
        check("both busy", {31'd0, busy_a}, 32'd0);
        check("both ready", {31'd0, ready_a}, 32'd0);
        @(posedge clk); #1;
        check("both err_pulse_ends", {31'd0, err_a}, 32'd0);
        check("both still_idle", {31'd0, busy_a}, 32'd0);

        // Strobe during WAIT: error pulse, original read still completes
        drive(0, 1'b1, 1'b0, 16'h0012, 16'h0000);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 16'h0012, 16'hDEAD);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        check("wait_strobe err", {31'd0, err_a}, 32'd1);
        check("wait_strobe busy", {31'd0, busy_a}, 32'd1);
        @(posedge clk); #1;
        check("wait_strobe no_early_ready", {31'd0, ready_a}, 32'd0);
        check("wait_strobe err_pulse_ends", {31'd0, err_a}, 32'd0);
        @(posedge clk); #1;
        check("wait_strobe ready", {31'd0, ready_a}, 32'd1);
        check("wait_strobe rdata", {16'd0, rdata_a}, 32'h0000BEEF);
        check("wait_strobe resp_err", {31'd0, err_a}, 32'd0);
        txn(0, 1'b1, 1'b0, 16'h0012, 16'h0000, 16'hBEEF, 1'b0, "dropped_write");

        // Reset in the middle of a write: the write must not land
        txn(0, 1'b0, 1'b1, 16'h0005, 16'h1111, 16'hBEEF, 1'b0, "pre_write5");
        drive(0, 1'b0, 1'b1, 16'h0005, 16'hAAAA);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("midreset busy", {31'd0, busy_a}, 32'd0);
        check("midreset rdata", {16'd0, rdata_a}, 32'd0);
        repeat (4) begin
            @(posedge clk); #1;
            check("midreset no_ready", {31'd0, ready_a}, 32'd0);
        end
        txn(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h1111, 1'b0, "read5_after_reset");

        // WAIT_CYCLES=0 instance: single-cycle latency, requests every 2 cycles
        txn(1, 1'b0, 1'b1, 16'h0030, 16'h0C0C, 16'h0000, 1'b0, "w0_wr30");
        txn(1, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h0C0C, 1'b0, "w0_rd30a");
        txn(1, 1'b0, 1'b1, 16'h0031, 16'h3C3C, 16'h0C0C, 1'b0, "w0_wr31");
        txn(1, 1'b1, 1'b0, 16'h0031, 16'h0000, 16'h3C3C, 1'b0, "w0_rd31");
        txn(1, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h0C0C, 1'b0, "w0_rd30b");
        txn(1, 1'b1, 1'b0, 16'h0031, 16'h0000, 16'h3C3C, 1'b0, "w0_rd31b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Data-memory responder for the 16-bit multicycle processor: the slave end of the MemRead/MemWrite strobes issued by the controller FSM in its MEM_LW and MEM_SW states.
- Latches a single-cycle request, inserts a configurable number of wait states, then performs the access.
- Returns read data with a one-cycle ready pulse, so the datapath can stall the FSM until the data is valid.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 8, implemented word-address bits; DEPTH = 2**ADDR_W words
- WAIT_CYCLES, 2, wait states between request capture and response (0..15)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- MemRead  in  1  read request strobe, sampled in IDLE only
- MemWrite  in  1  write request strobe, sampled in IDLE only
- addr  in  16  word address (ALU result), sampled with the strobe
- wdata  in  DATA_W  store data, sampled with the strobe
- rdata  out  DATA_W  read data; holds the last completed read
- mem_ready  out  1  one-cycle pulse when the access completes
- mem_busy  out  1  high from the cycle after capture through the RESP cycle
- mem_err  out  1  one-cycle pulse on a protocol or range error

Behaviour:
- Reset (rst=0 at clk edge) forces state IDLE and sets rdata=0, mem_ready=0, mem_busy=0, mem_err=0, wait counter=0. Array contents are not reset.
- A reset asserted mid-access aborts the access, and a pending write is not performed.
- State machine: IDLE -> WAIT -> RESP -> IDLE.
- IDLE, exactly one strobe high: latch the op, addr and wdata; load the counter with WAIT_CYCLES; set mem_busy=1 next cycle.
  - If WAIT_CYCLES=0, go directly to RESP.
  - Otherwise go to WAIT.
- IDLE, MemRead=1 and MemWrite=1 together: no access; pulse mem_err next cycle; stay in IDLE.
- WAIT: decrement the counter each cycle; move to RESP when the counter reaches 1.
  - Any strobes in WAIT or RESP are ignored and each one pulses mem_err; the request is dropped, not queued.
- RESP, read: rdata <= array[addr_q] and mem_ready=1 in the same registered cycle; next state IDLE.
- RESP, write: array[addr_q] <= wdata_q at this edge and mem_ready=1; rdata is unchanged; next state IDLE.
- Latency: a strobe at edge t gives mem_ready high during cycle t+1+WAIT_CYCLES.
  - For the default WAIT_CYCLES=2, mem_ready is high 3 cycles after the strobe edge.
- mem_busy drops in the cycle after RESP, so a new strobe is accepted in the first IDLE cycle after RESP.
- Range check: if addr[15:ADDR_W] != 0, the access still runs the full latency.
  - A read returns rdata=0.
  - A write is suppressed.
  - mem_err pulses together with mem_ready.
- Back-to-back requests: the minimum request spacing is WAIT_CYCLES+2 cycles.
- Read-after-write to the same address returns the new value: the write commits in RESP, before any later read.
- The array is synchronous single-port, with no read-during-write hazard because only one access is active at a time.

Decomposition:
- Shared package (proc_pkg) holds DATA_W, the state encodings (MR_IDLE=2'b00, MR_WAIT=2'b01, MR_RESP=2'b10) and the opcode constants OP_LW=4'b0001 and OP_SW=4'b0010.
  - These are the same values the controller uses, for bench decode.
- One sub-module, mem_array: parameterised DEPTH x DATA_W synchronous single-port RAM with a write enable, instantiated once.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release with no strobes -> rdata=0, mem_ready=0, mem_busy=0, mem_err=0.
- Write/read: MemWrite with addr=0x0012, wdata=0xBEEF -> mem_ready pulses 3 cycles later. Then MemRead with addr=0x0012 -> mem_ready 3 cycles later, rdata=0xBEEF and held until the next read.
- Out of range: MemWrite with addr=0x0112, wdata=0x1234 -> mem_ready and mem_err together. A read of addr=0x0112 returns 0 with mem_err. A read of 0x0012 still returns 0xBEEF.
- Protocol errors: MemRead and MemWrite high together in IDLE -> mem_err next cycle, no busy. A strobe during WAIT -> mem_err pulse, and the original access still completes with correct data.
- Reset mid-write: MemWrite with addr=0x0005, wdata=0xAAAA, then rst=0 during WAIT -> IDLE. A later read of 0x0005 does not return 0xAAAA (the prior value is kept).
- WAIT_CYCLES=0 build: a read strobe at edge t -> mem_ready during cycle t+1. Back-to-back reads every 2 cycles all complete without error.
